// File: rtl/sr_frame_sync_if.sv
`default_nettype none
// ============================================================================
//  Module   : sr_frame_sync_if
//  Purpose  : Bundle between the upstream shift register, the frame
//             synchroniser and the word consumer.
//  Signals  : sr_in / shift_valid / dir  - shifted bit stream from upstream
//             word_out / word_valid / word_ready / word_first - word handshake
//             locked / overrun           - status
//  Modports : master - stream source + word consumer (drives inputs)
//             slave  - frame synchroniser
//  Revision : 1.0 - initial release
// ============================================================================
interface sr_frame_sync_if #(
    parameter int MSB = 16
);
    logic [MSB-1:0] sr_in;
    logic           shift_valid;
    logic           dir;
    logic [MSB-1:0] word_out;
    logic           word_valid;
    logic           word_ready;
    logic           word_first;
    logic           locked;
    logic           overrun;

    modport master (
        output sr_in, shift_valid, dir, word_ready,
        input  word_out, word_valid, word_first, locked, overrun
    );

    modport slave (
        input  sr_in, shift_valid, dir, word_ready,
        output word_out, word_valid, word_first, locked, overrun
    );
endinterface
`default_nettype wire

// File: rtl/sr_frame_sync.sv
`default_nettype none
// ============================================================================
//  Module   : sr_frame_sync
//  Purpose  : Hunts for SYNC in the upstream shift-register contents, locks to
//             the frame grid and hands out FRAME_WORDS data words per frame
//             through a single-entry valid/ready holding register. Lock is
//             dropped after MAX_MISS consecutive bad sync slots or on any
//             change of shift direction.
//  Ports    : clk  - rising-edge clock
//             rstn - asynchronous active-low reset
//             bus  - sr_frame_sync_if.slave (stream in, word out, status)
//  Revision : 1.0 - initial release
// ============================================================================
module sr_frame_sync #(
    parameter int             MSB         = 16,
    parameter logic [MSB-1:0] SYNC        = MSB'(16'hB38F),
    parameter int             FRAME_WORDS = 4,
    parameter int             MAX_MISS    = 2
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    sr_frame_sync_if.slave   bus
);

    localparam int BCW = $clog2(MSB);
    localparam int WCW = $clog2(FRAME_WORDS + 1);
    localparam int MCW = $clog2(MAX_MISS + 1);

    localparam logic [BCW-1:0] c_bit_last  = BCW'(MSB - 1);
    localparam logic [WCW-1:0] c_sync_slot = WCW'(FRAME_WORDS);
    localparam logic [MCW-1:0] c_miss_lim  = MCW'(MAX_MISS);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_d;
    logic [BCW-1:0] r_bit_cnt;
    logic [BCW-1:0] w_bit_cnt_d;
    logic [WCW-1:0] r_word_cnt;
    logic [WCW-1:0] w_word_cnt_d;
    logic [MCW-1:0] r_miss_cnt;
    logic [MCW-1:0] w_miss_cnt_d;
    logic [MCW-1:0] w_miss_inc;
    logic           r_dir_q;
    logic           w_capture;
    logic           w_capture_first;

    logic [MSB-1:0] r_word_out;
    logic           r_word_valid;
    logic           r_word_first;
    logic           r_locked;
    logic           r_overrun;

    assign w_miss_inc = r_miss_cnt + MCW'(1);

    // ------------------------------------------------------------------
    // Next-state / slot decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d       = r_state;
        w_bit_cnt_d     = r_bit_cnt;
        w_word_cnt_d    = r_word_cnt;
        w_miss_cnt_d    = r_miss_cnt;
        w_capture       = 1'b0;
        w_capture_first = 1'b0;

        if (bus.dir != r_dir_q) begin
            // The bit order on sr_in just changed, so any alignment is void;
            // the shift in this same cycle is deliberately not matched.
            w_state_d    = HUNT;
            w_bit_cnt_d  = '0;
            w_word_cnt_d = '0;
            w_miss_cnt_d = '0;
        end else if (bus.shift_valid) begin
            case (r_state)
                HUNT: begin
                    // Checked on every bit, so overlapping candidates are seen.
                    if (bus.sr_in == SYNC) begin
                        w_state_d    = LOCKED;
                        w_bit_cnt_d  = '0;
                        w_word_cnt_d = '0;
                        w_miss_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (r_bit_cnt == c_bit_last) begin
                        w_bit_cnt_d = '0;
                        if (r_word_cnt != c_sync_slot) begin
                            w_capture       = 1'b1;
                            w_capture_first = (r_word_cnt == '0);
                            w_word_cnt_d    = r_word_cnt + WCW'(1);
                        end else begin
                            w_word_cnt_d = '0;
                            if (bus.sr_in == SYNC) begin
                                w_miss_cnt_d = '0;
                            end else if (w_miss_inc == c_miss_lim) begin
                                w_state_d    = HUNT;
                                w_miss_cnt_d = '0;
                            end else begin
                                w_miss_cnt_d = w_miss_inc;
                            end
                        end
                    end else begin
                        w_bit_cnt_d = r_bit_cnt + BCW'(1);
                    end
                end
                default: w_state_d = HUNT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= HUNT;
            r_bit_cnt    <= '0;
            r_word_cnt   <= '0;
            r_miss_cnt   <= '0;
            r_dir_q      <= 1'b0;
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
            r_word_first <= 1'b0;
            r_locked     <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_bit_cnt  <= w_bit_cnt_d;
            r_word_cnt <= w_word_cnt_d;
            r_miss_cnt <= w_miss_cnt_d;
            r_dir_q    <= bus.dir;
            // Registered from the next state so lock changes on the deciding edge.
            r_locked   <= (w_state_d == LOCKED);

            // Single-entry holding register: a consumer taking the old word
            // in the same cycle makes room for the new one.
            if (w_capture) begin
                if (!r_word_valid || bus.word_ready) begin
                    r_word_out   <= bus.sr_in;
                    r_word_first <= w_capture_first;
                    r_word_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_word_valid && bus.word_ready) begin
                r_word_valid <= 1'b0;
            end
        end
    end

    assign bus.word_out   = r_word_out;
    assign bus.word_valid = r_word_valid;
    assign bus.word_first = r_word_first;
    assign bus.locked     = r_locked;
    assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/sr_frame_sync.md
# sr_frame_sync

Frame synchroniser that sits directly downstream of `shift_reg` and consumes its parallel `out` bus. It hunts for a sync word in the shifted bit stream and locks to frame boundaries. It then delivers each following MSB-bit data word through a valid/ready handshake, dropping lock after repeated sync misses.

## Interface
- `MSB`, 16, word width; must equal the upstream `shift_reg` MSB; minimum 4.
- `SYNC`, 16'hB38F, MSB-bit sync pattern; must be non-zero.
- `FRAME_WORDS`, 4, data words between sync slots; minimum 1.
- `MAX_MISS`, 2, consecutive sync-slot mismatches that force loss of lock; minimum 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, asynchronous assert, active-low.
- `sr_in` in MSB: parallel contents of the upstream shift register.
- `shift_valid` in 1: high for one cycle per new bit present on `sr_in`. This is upstream `en` registered one cycle.
- `dir` in 1: upstream shift direction; a change invalidates alignment.
- `word_out` out MSB: captured data word.
- `word_valid` out 1: `word_out` holds an unconsumed word.
- `word_ready` in 1: consumer accepts the word when `word_valid && word_ready` at a rising edge.
- `word_first` out 1: qualifies `word_out` as the first data word after a sync slot.
- `locked` out 1: frame alignment held.
- `overrun` out 1: sticky; a word was dropped because the holding register was full.

## Operation
- FSM states are HUNT and LOCKED. Reset state is HUNT.
- **HUNT:** on each `shift_valid`, compare `sr_in` to `SYNC`. Overlapping matches are allowed, so the check runs every bit.
  - Match: go to LOCKED; clear `bit_cnt`, `word_cnt` and `miss_cnt`.
- **LOCKED:** each `shift_valid` increments `bit_cnt` (width clog2(MSB)). When a `shift_valid` arrives with `bit_cnt == MSB-1`, `bit_cnt` wraps to 0 and the slot completes:
  - Data slot (`word_cnt < FRAME_WORDS`): capture `sr_in` into the holding register. Set `word_first = (word_cnt == 0)`. Increment `word_cnt`.
  - Sync slot (`word_cnt == FRAME_WORDS`): compare `sr_in` to `SYNC` and clear `word_cnt`.
    - Match clears `miss_cnt`.
    - Mismatch increments `miss_cnt`. If the new value equals `MAX_MISS`, go to HUNT and deassert `locked`.
    - On a tolerated miss, the next frame is still delivered.
- **Holding register:** single entry.
  - A capture while empty, or while full with `word_ready=1` in the same cycle, loads the new word and `word_valid` stays or becomes 1.
  - A capture while full with `word_ready=0` discards the new word, keeps the old one and sets `overrun`.
  - Consumption without a capture clears `word_valid`.
- **dir change:** `dir` is registered internally as `dir_q`. `dir != dir_q` in any cycle forces HUNT at that edge and clears all counters. `shift_valid` in that cycle is ignored for matching. A pending word in the holding register is retained.
- `overrun` clears only on reset.
- `word_out` and `word_first` hold their values while `word_valid=0`.

## Timing
- Reset values: `word_out=0`, `word_valid=0`, `word_first=0`, `locked=0`, `overrun=0`, state HUNT, all counters 0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `locked` rises on the edge that samples the matching sync word and is visible the next cycle.
- `word_valid` and `word_out` update on the edge that samples the MSB-th data bit (latency 1 cycle from that `shift_valid`).
- `locked` falls on the edge that samples the final missed sync slot, or on the edge that sees the `dir` change.
- Reset mid-frame aborts immediately. Any pending word is lost and `overrun` is cleared.
- Maximum throughput: one word per MSB `shift_valid` pulses.
- Back-to-back `shift_valid` on every cycle is supported.

## Test plan
- **Lock and deliver:** reset, then shift in 0xB38F, 0x1234, 0x5678, 0x9ABC, 0xDEF0, 0xB38F one bit per cycle with `word_ready=1`.
  - `locked=1` after the first sync.
  - Four `word_valid` pulses carrying 0x1234, 0x5678, 0x9ABC, 0xDEF0.
  - `word_first=1` only with 0x1234.
  - `locked` stays 1 after the second sync.
- **Backpressure:** same stream with `word_ready=0`.
  - `word_out` holds 0x1234 with `word_valid=1`.
  - `overrun=1` from the edge capturing 0x5678 onward.
  - Raising `word_ready` for one cycle clears `word_valid`.
- **Miss tolerance:** with MAX_MISS=2, replace one sync slot with 0x0000.
  - `locked` stays 1 and the next frame is delivered.
  - A second consecutive 0x0000 sync slot drops `locked` to 0 at that edge.
- **Direction change:** while locked mid-word, toggle `dir`.
  - `locked=0` next cycle and no further words are produced.
  - A re-sent 0xB38F relocks.
- **Asynchronous reset:** deassert `rstn` between clock edges mid-frame.
  - All outputs go to 0 without waiting for a clock edge.
  - After release, no word appears until a fresh sync word is received.
- **Overlapping sync / no false lock:** shift random data excluding SYNC for 200 bits and check `locked` stays 0. Then send SYNC immediately after its own leading bits and check lock at the exact completing bit.
